// File: rtl/arith_pkg.sv
// arith_pkg: shared definitions for the multi-cycle arithmetic blocks.
//   stateT    - sequencing states of a multi-cycle operation
//   calcN     - number of chunks needed to cover a given width
//   calcCntW  - width of a chunk counter for N chunks (at least 1 bit)
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   function automatic int unsigned calcN(input int unsigned width, input int unsigned chunk);
      if (chunk == 0 || width < chunk) return 1;
      return width / chunk;
   endfunction

   function automatic int unsigned calcCntW(input int unsigned n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/chunk_add.sv
// chunk_add: combinational CHUNK-bit adder slice.
//   a, b  - addend slices
//   cin   - carry in from the previous slice
//   s     - CHUNK-bit sum
//   cout  - carry out of the slice MSB
module chunk_add #(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock.
//   clk      - rising-edge clock
//   reset    - asynchronous active-high reset
//   start    - request pulse, accepted in IDLE or DONE
//   sub      - 0: inA+inB, 1: inA-inB (sampled with start)
//   inA, inB - operands (sampled with start)
//   busy     - high while chunks are being processed
//   done     - one-cycle completion pulse
//   ans      - result, held until the next completion
//   carry    - carry out of the MSB (for sub: 1 = no borrow)
//   overflow - two's-complement signed overflow
module chunk_adder
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] ans,
   output logic             carry,
   output logic             overflow
);

   localparam int unsigned N    = calcN(WIDTH, CHUNK);
   localparam int unsigned CNTW = calcCntW(N);
   localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

   generate
      if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : gBadParam
         $error("chunk_adder: CHUNK must be nonzero and divide WIDTH evenly");
      end
   endgenerate

   stateT            state;
   stateT            stateNext;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] fullResult;
   logic [WIDTH-1:0] sumTop;
   logic             cin;
   logic [CNTW-1:0]  count;
   logic             aMsb;
   logic             bMsb;
   logic [CHUNK-1:0] chunkSum;
   logic             chunkCarry;
   logic             accept;
   logic             lastChunk;

   assign accept    = start && (state == IDLE || state == DONE);
   assign lastChunk = (state == RUN) && (count == LAST);

   // Single adder slice, fed each cycle with the low chunk of the shifting operands.
   chunk_add #(
      .CHUNK(CHUNK)
   ) uChunkAdd (
      .a   (opA[CHUNK-1:0]),
      .b   (opB[CHUNK-1:0]),
      .cin (cin),
      .s   (chunkSum),
      .cout(chunkCarry)
   );

   // New sum enters at the top while earlier chunks move down; after N cycles
   // chunk 0 sits in the LSBs. Shift form also covers N == 1 without slicing.
   assign sumTop     = WIDTH'(chunkSum) << (WIDTH - CHUNK);
   assign fullResult = (partial >> CHUNK) | sumTop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (start) stateNext = RUN;
         RUN:     if (count == LAST) stateNext = DONE;
         DONE:    stateNext = start ? RUN : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opA      <= '0;
         opB      <= '0;
         partial  <= '0;
         cin      <= 1'b0;
         count    <= '0;
         aMsb     <= 1'b0;
         bMsb     <= 1'b0;
         ans      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         opA   <= inA;
         opB   <= sub ? ~inB : inB;
         cin   <= sub;
         count <= '0;
         aMsb  <= inA[WIDTH-1];
         bMsb  <= sub ? ~inB[WIDTH-1] : inB[WIDTH-1];
      end else if (state == RUN) begin
         opA     <= opA >> CHUNK;
         opB     <= opB >> CHUNK;
         partial <= fullResult;
         cin     <= chunkCarry;
         count   <= count + CNTW'(1);
         if (lastChunk) begin
            ans      <= fullResult;
            carry    <= chunkCarry;
            // Same-sign operands producing an opposite-sign result.
            overflow <= (aMsb == bMsb) && (fullResult[WIDTH-1] != aMsb);
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_chunk_adder.sv
module tb_chunk_adder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        start2 = 1'b0;
   logic        sub = 1'b0;
   logic [31:0] inA = '0;
   logic [31:0] inB = '0;
   logic        busy, done, carry, overflow;
   logic [31:0] ans;
   logic        busy2, done2, carry2, overflow2;
   logic [31:0] ans2;

   int nChecks = 0;
   int nPass = 0;

   always #5 clk = ~clk;

   chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .reset(reset), .start(start), .sub(sub), .inA(inA), .inB(inB),
      .busy(busy), .done(done), .ans(ans), .carry(carry), .overflow(overflow)
   );

   chunk_adder #(.WIDTH(32), .CHUNK(32)) dut32 (
      .clk(clk), .reset(reset), .start(start2), .sub(sub), .inA(inA), .inB(inB),
      .busy(busy2), .done(done2), .ans(ans2), .carry(carry2), .overflow(overflow2)
   );

   // Issue one request on the main DUT and wait (bounded) for done.
   // edges: clock edges after the accept edge until done is seen.
   task automatic runOp(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int busyCnt);
      @(negedge clk);
      sub = s; inA = a; inB = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 0; busyCnt = 0;
      while (!done && edges < 20) begin
         if (busy) busyCnt++;
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset;
      #1;
      nChecks++;
      if ({busy, done, carry, overflow, ans} !== 36'h0) begin
         $display("FAIL reset_outputs: got busy=%b done=%b c=%b o=%b ans=%h, want all 0",
                  busy, done, carry, overflow, ans);
      end else nPass++;
      nChecks++;
      if ({busy2, done2, carry2, overflow2, ans2} !== 36'h0) begin
         $display("FAIL reset_outputs32: got busy=%b done=%b ans=%h, want all 0",
                  busy2, done2, ans2);
      end else nPass++;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      nChecks++;
      if ({busy, done} !== 2'b00) begin
         $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
      end else nPass++;
   endtask

   task automatic test_add_wrap;
      int e, bc;
      runOp(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, e, bc);
      nChecks++;
      if (e !== 4) $display("FAIL add_wrap_latency: got %0d edges, want 4", e);
      else nPass++;
      nChecks++;
      if (bc !== 4) $display("FAIL add_wrap_busy: got %0d busy cycles, want 4", bc);
      else nPass++;
      nChecks++;
      if ({ans, carry, overflow} !== {32'h0000_0000, 1'b1, 1'b0}) begin
         $display("FAIL add_wrap_result: got ans=%h c=%b o=%b, want 00000000 1 0",
                  ans, carry, overflow);
      end else nPass++;
      nChecks++;
      if (busy !== 1'b0) $display("FAIL add_wrap_busy_in_done: got %b, want 0", busy);
      else nPass++;
      @(posedge clk); #1;
      nChecks++;
      if ({busy, done} !== 2'b00) begin
         $display("FAIL done_one_cycle: got busy=%b done=%b, want 0 0", busy, done);
      end else nPass++;
   endtask

   task automatic test_add_ovf;
      int e, bc;
      runOp(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, e, bc);
      nChecks++;
      if (e !== 4 || {ans, carry, overflow} !== {32'h8000_0000, 1'b1 ^ 1'b1, 1'b1}) begin
         $display("FAIL add_ovf: got edges=%0d ans=%h c=%b o=%b, want 4 80000000 0 1",
                  e, ans, carry, overflow);
      end else nPass++;
      @(posedge clk);
   endtask

   task automatic test_sub;
      int e, bc;
      runOp(1'b1, 32'd5, 32'd7, e, bc);
      nChecks++;
      if (e !== 4 || {ans, carry, overflow} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
         $display("FAIL sub_neg: got edges=%0d ans=%h c=%b o=%b, want 4 fffffffe 0 0",
                  e, ans, carry, overflow);
      end else nPass++;
      @(posedge clk);
      runOp(1'b1, 32'h8000_0000, 32'h0000_0001, e, bc);
      nChecks++;
      if (e !== 4 || {ans, carry, overflow} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
         $display("FAIL sub_ovf: got edges=%0d ans=%h c=%b o=%b, want 4 7fffffff 1 1",
                  e, ans, carry, overflow);
      end else nPass++;
      @(posedge clk);
   endtask

   task automatic test_start_held;
      int e;
      @(negedge clk);
      sub = 1'b0; inA = 32'h0000_0010; inB = 32'h0000_0020; start = 1'b1;
      @(posedge clk); #1;
      e = 0;
      // Keep start high and scramble the operands while the operation runs.
      while (!done && e < 20) begin
         sub = ~sub; inA = inA ^ 32'hDEAD_BEEF; inB = inB + 32'h0101_0101;
         @(posedge clk); #1;
         e++;
      end
      start = 1'b0;
      nChecks++;
      if (e !== 4 || {ans, carry, overflow} !== {32'h0000_0030, 1'b0, 1'b0}) begin
         $display("FAIL start_held: got edges=%0d ans=%h c=%b o=%b, want 4 00000030 0 0",
                  e, ans, carry, overflow);
      end else nPass++;
      @(posedge clk); #1;
      nChecks++;
      if ({busy, done} !== 2'b00) begin
         $display("FAIL start_held_idle: got busy=%b done=%b, want 0 0", busy, done);
      end else nPass++;
   endtask

   task automatic test_back_to_back;
      int e, bc;
      runOp(1'b0, 32'h0000_0100, 32'h0000_0200, e, bc);
      nChecks++;
      if (e !== 4 || ans !== 32'h0000_0300) begin
         $display("FAIL b2b_first: got edges=%0d ans=%h, want 4 00000300", e, ans);
      end else nPass++;
      // Still in the DONE cycle: request the next operation.
      sub = 1'b1; inA = 32'h0000_0010; inB = 32'h0000_0003; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      nChecks++;
      if ({busy, done, ans} !== {1'b1, 1'b0, 32'h0000_0300}) begin
         $display("FAIL b2b_accept: got busy=%b done=%b ans=%h, want 1 0 00000300",
                  busy, done, ans);
      end else nPass++;
      e = 0;
      while (!done && e < 20) begin
         @(posedge clk); #1;
         e++;
      end
      nChecks++;
      if (e !== 4 || {ans, carry, overflow} !== {32'h0000_000D, 1'b1, 1'b0}) begin
         $display("FAIL b2b_second: got edges=%0d ans=%h c=%b o=%b, want 4 0000000d 1 0",
                  e, ans, carry, overflow);
      end else nPass++;
      @(posedge clk);
   endtask

   task automatic test_reset_mid;
      int e, bc;
      logic sawDone;
      @(negedge clk);
      sub = 1'b0; inA = 32'hAAAA_AAAA; inB = 32'h1111_1111; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      nChecks++;
      if ({busy, done, carry, overflow, ans} !== 36'h0) begin
         $display("FAIL reset_mid_outputs: got busy=%b done=%b c=%b o=%b ans=%h, want all 0",
                  busy, done, carry, overflow, ans);
      end else nPass++;
      @(posedge clk);
      @(negedge clk); reset = 1'b0;
      sawDone = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done || busy) sawDone = 1'b1;
      end
      nChecks++;
      if (sawDone !== 1'b0) $display("FAIL reset_mid_no_done: got activity=1, want 0");
      else nPass++;
      runOp(1'b0, 32'h1234_5678, 32'h1111_1111, e, bc);
      nChecks++;
      if (e !== 4 || {ans, carry, overflow} !== {32'h2345_6789, 1'b0, 1'b0}) begin
         $display("FAIL reset_mid_rerun: got edges=%0d ans=%h c=%b o=%b, want 4 23456789 0 0",
                  e, ans, carry, overflow);
      end else nPass++;
      @(posedge clk);
   endtask

   task automatic test_chunk32;
      int e, bc;
      @(negedge clk);
      sub = 1'b0; inA = 32'hFFFF_FFFF; inB = 32'h0000_0001; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      e = 0; bc = 0;
      while (!done2 && e < 20) begin
         if (busy2) bc++;
         @(posedge clk); #1;
         e++;
      end
      nChecks++;
      if (e !== 1 || bc !== 1) begin
         $display("FAIL chunk32_latency: got edges=%0d busy=%0d, want 1 1", e, bc);
      end else nPass++;
      nChecks++;
      if ({ans2, carry2, overflow2} !== {32'h0000_0000, 1'b1, 1'b0}) begin
         $display("FAIL chunk32_result: got ans=%h c=%b o=%b, want 00000000 1 0",
                  ans2, carry2, overflow2);
      end else nPass++;
      @(posedge clk); #1;
      nChecks++;
      if ({busy2, done2} !== 2'b00) begin
         $display("FAIL chunk32_idle: got busy=%b done=%b, want 0 0", busy2, done2);
      end else nPass++;
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_add_ovf();
      test_sub();
      test_start_held();
      test_back_to_back();
      test_reset_mid();
      test_chunk32();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
